mux4_1_rr: RTL and testbench

- Four-to-one merging multiplexer; the inverse of the team's 1-to-4 demux.
- Merges four independent `width`-bit source channels into one output stream.
- Uses round-robin arbitration, a valid/ready handshake on every side, and a single registered output stage.
- Sits upstream of a single consumer and reports which channel each beat came from on `{s1, s0}`, using the same select encoding the demux consumes.

---
 rtl/mux_pkg.sv | 11 +
 rtl/rr_arb4.sv | 31 +++
 rtl/mux4_1_rr.sv | 122 ++++++++++++
 tb/tb_mux4_1_rr.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// rtl/mux_pkg.sv - shared select encoding and defaults for the 4-channel mux/demux pair
package mux_pkg;
    localparam int NCH = 4;

    localparam logic [1:0] SEL_CH0 = 2'b00;
    localparam logic [1:0] SEL_CH1 = 2'b01;
    localparam logic [1:0] SEL_CH2 = 2'b10;
    localparam logic [1:0] SEL_CH3 = 2'b11;

    localparam logic [7:0] IDLE_DEFAULT = 8'h0F;
endpackage

// File: rtl/rr_arb4.sv
// rtl/rr_arb4.sv - combinational 4-way round-robin arbiter starting after the last grant
module rr_arb4
    import mux_pkg::*;
(
    input  logic [NCH-1:0] req,
    input  logic [1:0]     last,
    input  logic           en,
    output logic [NCH-1:0] gnt,
    output logic [1:0]     gnt_idx
);
    logic       found;
    logic [1:0] idx;

    always_comb begin
        gnt     = '0;
        gnt_idx = SEL_CH0;
        found   = 1'b0;
        idx     = last;
        // Two-bit index wraps naturally, so last+1..last+4 visits every channel once.
        for (int i = 1; i <= NCH; i++) begin
            idx = last + 2'(i);
            if (!found && req[idx]) begin
                found   = 1'b1;
                gnt_idx = idx;
            end
        end
        if (found && en) begin
            gnt[gnt_idx] = 1'b1;
        end
    end
endmodule

// File: rtl/mux4_1_rr.sv
// rtl/mux4_1_rr.sv - 4:1 round-robin merging mux with registered output; MUX4_1_RR_GRANT_CNT_EN adds per-channel grant counters
module mux4_1_rr
    import mux_pkg::*;
#(
    parameter int         width = 8,
    parameter logic [7:0] IDLE  = IDLE_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [width-1:0] D0,
    input  logic [width-1:0] D1,
    input  logic [width-1:0] D2,
    input  logic [width-1:0] D3,
    input  logic             v0,
    input  logic             v1,
    input  logic             v2,
    input  logic             v3,
    output logic             r0,
    output logic             r1,
    output logic             r2,
    output logic             r3,
    output logic [width-1:0] Y,
    output logic             Y_valid,
    input  logic             Y_ready,
    output logic             s1,
    output logic             s0
`ifdef MUX4_1_RR_GRANT_CNT_EN
    ,
    output logic [15:0]      cnt0,
    output logic [15:0]      cnt1,
    output logic [15:0]      cnt2,
    output logic [15:0]      cnt3
`endif
);
    localparam logic [width-1:0] IDLE_W = width'(IDLE);

    logic [width-1:0] y_q, y_d;
    logic             y_valid_q, y_valid_d;
    logic [1:0]       sel_q, sel_d;
    logic [1:0]       last_q, last_d;

    logic [width-1:0] d_arr [NCH];
    logic [NCH-1:0]   req, gnt;
    logic [1:0]       gnt_idx;
    logic             load, xfer;

    assign d_arr[0] = D0;
    assign d_arr[1] = D1;
    assign d_arr[2] = D2;
    assign d_arr[3] = D3;
    assign req      = {v3, v2, v1, v0};

    // Ready is suppressed during reset so no beat is lost into a register being cleared.
    assign load = (!y_valid_q || Y_ready) && !rst;

    rr_arb4 u_arb (
        .req     (req),
        .last    (last_q),
        .en      (load),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    assign {r3, r2, r1, r0} = gnt;
    assign xfer             = |gnt;

    always_comb begin
        y_d       = y_q;
        y_valid_d = y_valid_q;
        sel_d     = sel_q;
        last_d    = last_q;
        if (xfer) begin
            y_d       = d_arr[gnt_idx];
            y_valid_d = 1'b1;
            sel_d     = gnt_idx;
            last_d    = gnt_idx;
        end else if (y_valid_q && Y_ready) begin
            y_d       = IDLE_W;
            y_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            y_q       <= IDLE_W;
            y_valid_q <= 1'b0;
            sel_q     <= SEL_CH0;
            last_q    <= SEL_CH3;
        end else begin
            y_q       <= y_d;
            y_valid_q <= y_valid_d;
            sel_q     <= sel_d;
            last_q    <= last_d;
        end
    end

    assign Y        = y_q;
    assign Y_valid  = y_valid_q;
    assign {s1, s0} = sel_q;

`ifdef MUX4_1_RR_GRANT_CNT_EN
    logic [15:0] cnt_q [NCH];
    logic [15:0] cnt_d [NCH];

    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            cnt_d[i] = cnt_q[i] + {15'd0, gnt[i]};
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NCH; i++) begin
            cnt_q[i] <= rst ? 16'd0 : cnt_d[i];
        end
    end

    assign cnt0 = cnt_q[0];
    assign cnt1 = cnt_q[1];
    assign cnt2 = cnt_q[2];
    assign cnt3 = cnt_q[3];
`endif
endmodule

// File: tb/tb_mux4_1_rr.sv
// tb/tb_mux4_1_rr.sv - directed self-checking bench for mux4_1_rr
module tb_mux4_1_rr;
    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] D0, D1, D2, D3;
    logic       v0, v1, v2, v3;
    logic       r0, r1, r2, r3;
    logic [7:0] Y;
    logic       Y_valid, Y_ready;
    logic       s1, s0;
`ifdef MUX4_1_RR_GRANT_CNT_EN
    logic [15:0] cnt0, cnt1, cnt2, cnt3;
`endif

    int checks = 0;
    int errors = 0;

    mux4_1_rr #(.width(8), .IDLE(8'h0F)) dut (
        .clk(clk), .rst(rst),
        .D0(D0), .D1(D1), .D2(D2), .D3(D3),
        .v0(v0), .v1(v1), .v2(v2), .v3(v3),
        .r0(r0), .r1(r1), .r2(r2), .r3(r3),
        .Y(Y), .Y_valid(Y_valid), .Y_ready(Y_ready),
        .s1(s1), .s0(s0)
`ifdef MUX4_1_RR_GRANT_CNT_EN
        , .cnt0(cnt0), .cnt1(cnt1), .cnt2(cnt2), .cnt3(cnt3)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_v(input logic [3:0] v);
        {v3, v2, v1, v0} = v;
        #1;
    endtask

    task automatic check_out(input string tag, input logic [7:0] y, input logic vld, input logic [1:0] sel);
        check({tag, "_y"}, {24'd0, Y}, {24'd0, y});
        check({tag, "_vld"}, {31'd0, Y_valid}, {31'd0, vld});
        check({tag, "_sel"}, {30'd0, s1, s0}, {30'd0, sel});
    endtask

    task automatic check_r(input string tag, input logic [3:0] r);
        check(tag, {28'd0, r3, r2, r1, r0}, {28'd0, r});
    endtask

    initial begin
        rst = 1'b1;
        Y_ready = 1'b1;
        D0 = 8'hA0; D1 = 8'hA1; D2 = 8'hA2; D3 = 8'hA3;
        set_v(4'b1111);
        step();
        step();
        check_out("reset", 8'h0F, 1'b0, 2'b00);
        check_r("reset_r", 4'b0000);

        rst = 1'b0;
        #1;
        check_r("first_grant_r", 4'b0001);

        step(); check_out("rr0", 8'hA0, 1'b1, 2'b00);
        step(); check_out("rr1", 8'hA1, 1'b1, 2'b01);
        step(); check_out("rr2", 8'hA2, 1'b1, 2'b10);
        step(); check_out("rr3", 8'hA3, 1'b1, 2'b11);
        step(); check_out("rr4", 8'hA0, 1'b1, 2'b00);
        step(); check_out("rr5", 8'hA1, 1'b1, 2'b01);

        Y_ready = 1'b0;
        #1;
        check_r("stall_r", 4'b0000);
        for (int i = 0; i < 3; i++) begin
            step();
            check_out("stall", 8'hA1, 1'b1, 2'b01);
            check_r("stall_r_hold", 4'b0000);
        end
        Y_ready = 1'b1;
        #1;
        check_r("release_r", 4'b0100);
        step(); check_out("release", 8'hA2, 1'b1, 2'b10);

        D3 = 8'h33;
        set_v(4'b1000);
        check_r("sparse3_r", 4'b1000);
        step(); check_out("sparse3", 8'h33, 1'b1, 2'b11);
        D1 = 8'h11;
        set_v(4'b0010);
        step(); check_out("sparse1", 8'h11, 1'b1, 2'b01);
        set_v(4'b1000);
        step(); check_out("wrap_pre", 8'h33, 1'b1, 2'b11);
        set_v(4'b0011);
        check_r("wrap_r", 4'b0001);
        step(); check_out("wrap", 8'hA0, 1'b1, 2'b00);

        D2 = 8'h5A;
        set_v(4'b0100);
        step(); check_out("drain_load", 8'h5A, 1'b1, 2'b10);
        set_v(4'b0000);
        check_r("no_req_r", 4'b0000);
        step(); check_out("drain_idle", 8'h0F, 1'b0, 2'b10);
        step(); check_out("idle_hold", 8'h0F, 1'b0, 2'b10);

        set_v(4'b0001);
        step(); check_out("pre_rst", 8'hA0, 1'b1, 2'b00);
        Y_ready = 1'b0;
        rst = 1'b1;
        set_v(4'b1111);
        check_r("rst_mid_r", 4'b0000);
        Y_ready = 1'b1;
        #1;
        check_r("rst_mid_r_ready", 4'b0000);
        step(); check_out("rst_mid", 8'h0F, 1'b0, 2'b00);
        rst = 1'b0;
        #1;
        check_r("rst_ptr_r", 4'b0001);

`ifdef MUX4_1_RR_GRANT_CNT_EN
        for (int i = 0; i < 10; i++) step();
        check("cnt0_rr", {16'd0, cnt0}, 32'd3);
        check("cnt1_rr", {16'd0, cnt1}, 32'd3);
        check("cnt2_rr", {16'd0, cnt2}, 32'd2);
        check("cnt3_rr", {16'd0, cnt3}, 32'd2);
        rst = 1'b1;
        set_v(4'b0001);
        step();
        check("cnt0_rst", {16'd0, cnt0}, 32'd0);
        rst = 1'b0;
        #1;
        for (int i = 0; i < 65535; i++) step();
        check("cnt0_max", {16'd0, cnt0}, 32'hFFFF);
        step();
        check("cnt0_wrap", {16'd0, cnt0}, 32'd0);
        check("cnt1_wrap", {16'd0, cnt1}, 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
